chirp_frame_sched: RTL
======================

CHIRP_FRAME_SCHED -- requirements
Module: chirp_frame_sched

Interface
REQ-001 SHALL have parameter RAMP_TIMEOUT, default 65535, meaning max cycles waiting for ramp_done_i before abort.
REQ-002 SHALL have parameter CHIRP_W, default 5, meaning width of chirp count/index.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable_i, input, 1, FMCW frame scheduling enable; low = CW/idle.
REQ-006 SHALL have port frame_period_i, input, 32, frame period in clk cycles.
REQ-007 SHALL have port chirp_num_i, input, CHIRP_W, chirps per frame.
REQ-008 SHALL have port chirp_gap_i, input, 16, idle cycles between ramp_done and next trigger.
REQ-009 SHALL have port adc_delay_i, input, 8, cycles from trigger to ADC window open.
REQ-010 SHALL have port ramp_done_i, input, 1, single-cycle done pulse from the VCO ramp generator.
REQ-011 SHALL have port ramp_trigger_o, output, 1, single-cycle ramp start pulse.
REQ-012 SHALL have port adc_win_o, output, 1, ADC sampling window.
REQ-013 SHALL have port chirp_idx_o, output, CHIRP_W, index of current chirp.
REQ-014 SHALL have ports frame_start_o, frame_done_o, overrun_o, outputs, 1 each, single-cycle event pulses.
REQ-015 SHALL have ports busy_o and timeout_err_o, outputs, 1 each; timeout_err_o is sticky.

Function
REQ-016 Frame timer SHALL count 0..P-1 while enable_i=1, where P = max(frame_period_i, 2); frame_tick is asserted when count = P-1.
REQ-017 FSM states SHALL be IDLE, TRIG, RAMP, GAP.
REQ-018 In IDLE, on frame_tick with chirp_num_i != 0, the FSM SHALL latch chirp_num_i, chirp_gap_i and adc_delay_i, pulse frame_start_o, clear chirp_idx_o and enter TRIG on the next cycle.
REQ-019 On frame_tick with chirp_num_i = 0, the FSM SHALL remain in IDLE with no output pulses.
REQ-020 TRIG SHALL assert ramp_trigger_o for exactly one cycle, then enter RAMP.
REQ-021 In RAMP, adc_win_o SHALL rise adc_delay cycles after the ramp_trigger_o cycle; delay 0 means it rises in the first RAMP cycle.
REQ-022 In RAMP, adc_win_o SHALL fall in the cycle after ramp_done_i is sampled.
REQ-023 On ramp_done_i in RAMP with chirp_idx_o = N-1, the FSM SHALL pulse frame_done_o and enter IDLE.
REQ-024 On ramp_done_i in RAMP with chirp_idx_o < N-1, the FSM SHALL increment chirp_idx_o and enter GAP; with gap = 0 it SHALL enter TRIG directly.
REQ-025 GAP SHALL last exactly gap cycles, then enter TRIG.
REQ-026 If ramp_done_i arrives before adc_win_o has risen, the window SHALL never open for that chirp.
REQ-027 ramp_done_i outside RAMP SHALL be ignored.
REQ-028 If frame_tick occurs while the FSM is not in IDLE, the block SHALL pulse overrun_o, skip that frame and keep the timer free-running.
REQ-029 If RAMP lasts RAMP_TIMEOUT cycles without ramp_done_i, the block SHALL set timeout_err_o, drop adc_win_o and enter IDLE without frame_done_o.
REQ-030 timeout_err_o SHALL clear only on reset or on a falling edge of enable_i.
REQ-031 If enable_i falls mid-frame, the block SHALL enter IDLE next cycle, drop all outputs and zero the timer and chirp_idx_o; a pending ramp is abandoned.
REQ-032 busy_o SHALL be high whenever the state is not IDLE.
REQ-033 Config inputs SHALL have no effect mid-frame except frame_period_i, which affects the next timer compare.

Reset
REQ-034 While rst_n=0, the block SHALL hold state = IDLE, the timer, gap and delay counters and chirp_idx_o at 0, and every output at 0.
REQ-035 The first frame_tick after reset release SHALL occur P cycles after the first enabled cycle.

Structure
REQ-036 Package vco_ctrl_pkg SHALL hold the FSM state encoding (2-bit) and the CW/FMCW mode constants, shared with the VCO wrapper.
REQ-037 The frame timer SHALL be a sub-module, frame_timer (period in, enable, tick out).

Verification
REQ-038 P=100, N=3, gap=4, delay=2, ramp_done 20 cycles after each trigger -> triggers 25 cycles apart, one frame_start and one frame_done, chirp_idx 0,1,2.
REQ-039 P=40, N=3, ramp 20 cycles -> overrun_o pulses at the next tick and the frame completes normally.
REQ-040 RAMP_TIMEOUT=50 with ramp_done_i never asserted -> timeout_err_o set at cycle 50 of RAMP, FSM in IDLE, no frame_done_o.
REQ-041 enable_i dropped during GAP -> all outputs 0 next cycle; after re-enable, frame_start_o occurs P cycles later.
REQ-042 delay=10 with ramp_done_i 5 cycles after trigger -> adc_win_o never asserts; gap=0 -> next trigger in the cycle after ramp_done_i.
REQ-043 chirp_num_i=0 -> no trigger and no frame pulses over 3 periods; rst_n asserted mid-RAMP -> all outputs 0 immediately.

Source files
------------

// File: rtl/vco_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// vco_ctrl_pkg : scheduler state encoding and VCO mode constants
// Rev 1.0
// ============================================================================
package vco_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRIG = 2'd1,
        ST_RAMP = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_t;

    localparam logic        c_mode_cw   = 1'b0;
    localparam logic        c_mode_fmcw = 1'b1;
    localparam logic [31:0] c_min_period = 32'd2;

    // Periods below two cycles would make the tick continuous.
    function automatic logic [31:0] eff_period(input logic [31:0] period);
        return (period < c_min_period) ? c_min_period : period;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// ============================================================================
// frame_timer : free-running frame counter, ticks on the last cycle of a period
// Rev 1.0
// ============================================================================
module frame_timer
    import vco_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    input  logic [31:0] i_period,
    output logic        o_tick
);

    logic [31:0] r_cnt;
    logic [31:0] w_last;
    logic        w_wrap;

    assign w_last = eff_period(i_period) - 32'd1;
    // >= lets a shortened period take effect without running through 2^32.
    assign w_wrap = (r_cnt >= w_last);
    assign o_tick = i_enable && w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_enable || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/chirp_frame_sched.sv
`default_nettype none
// ============================================================================
// chirp_frame_sched : FMCW frame/chirp sequencer driving VCO ramp and ADC window
// Rev 1.0
// ============================================================================
module chirp_frame_sched
    import vco_ctrl_pkg::*;
#(
    parameter int unsigned RAMP_TIMEOUT = 65535,
    parameter int unsigned CHIRP_W      = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_i,
    input  logic [31:0]        frame_period_i,
    input  logic [CHIRP_W-1:0] chirp_num_i,
    input  logic [15:0]        chirp_gap_i,
    input  logic [7:0]         adc_delay_i,
    input  logic               ramp_done_i,
    output logic               ramp_trigger_o,
    output logic               adc_win_o,
    output logic [CHIRP_W-1:0] chirp_idx_o,
    output logic               frame_start_o,
    output logic               frame_done_o,
    output logic               overrun_o,
    output logic               busy_o,
    output logic               timeout_err_o
);

    localparam logic [31:0] c_rto_last = 32'(RAMP_TIMEOUT - 1);

    sched_state_t       r_state;
    logic [CHIRP_W-1:0] r_num;
    logic [CHIRP_W-1:0] r_idx;
    logic [15:0]        r_gap;
    logic [15:0]        r_gcnt;
    logic [7:0]         r_dly;
    logic [31:0]        r_rcnt;
    logic               r_trig, r_win, r_fstart, r_fdone, r_ovr, r_tmo;

    logic               w_tick;
    logic               w_fmcw;
    logic               w_last_chirp;
    logic               w_open_next;

    frame_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_enable (enable_i),
        .i_period (frame_period_i),
        .o_tick   (w_tick)
    );

    assign w_fmcw       = (enable_i == c_mode_fmcw);
    assign w_last_chirp = (r_idx == (r_num - CHIRP_W'(1)));
    // r_rcnt is the RAMP cycle index; the window opens at trigger + max(delay,1).
    assign w_open_next  = ({1'b0, r_rcnt} + 33'd2) >= {25'd0, r_dly};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_num    <= '0;
            r_idx    <= '0;
            r_gap    <= '0;
            r_gcnt   <= '0;
            r_dly    <= '0;
            r_rcnt   <= '0;
            r_trig   <= 1'b0;
            r_win    <= 1'b0;
            r_fstart <= 1'b0;
            r_fdone  <= 1'b0;
            r_ovr    <= 1'b0;
            r_tmo    <= 1'b0;
        end else if (!w_fmcw) begin
            // Held low, so the sticky error is released on the falling edge.
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_gcnt   <= '0;
            r_rcnt   <= '0;
            r_trig   <= 1'b0;
            r_win    <= 1'b0;
            r_fstart <= 1'b0;
            r_fdone  <= 1'b0;
            r_ovr    <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            r_trig   <= 1'b0;
            r_fstart <= 1'b0;
            r_fdone  <= 1'b0;
            r_ovr    <= w_tick && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_tick && (chirp_num_i != '0)) begin
                        r_num    <= chirp_num_i;
                        r_gap    <= chirp_gap_i;
                        r_dly    <= adc_delay_i;
                        r_idx    <= '0;
                        r_fstart <= 1'b1;
                        r_trig   <= 1'b1;
                        r_state  <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    r_rcnt  <= '0;
                    r_win   <= (r_dly <= 8'd1);
                    r_state <= ST_RAMP;
                end
                ST_RAMP: begin
                    if (ramp_done_i) begin
                        r_win <= 1'b0;
                        if (w_last_chirp) begin
                            r_fdone <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + CHIRP_W'(1);
                            if (r_gap == 16'd0) begin
                                r_trig  <= 1'b1;
                                r_state <= ST_TRIG;
                            end else begin
                                r_gcnt  <= r_gap;
                                r_state <= ST_GAP;
                            end
                        end
                    end else if (r_rcnt == c_rto_last) begin
                        r_tmo   <= 1'b1;
                        r_win   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_rcnt <= r_rcnt + 32'd1;
                        if (w_open_next) begin
                            r_win <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gcnt <= 16'd1) begin
                        r_trig  <= 1'b1;
                        r_state <= ST_TRIG;
                    end else begin
                        r_gcnt <= r_gcnt - 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ramp_trigger_o = r_trig;
    assign adc_win_o      = r_win;
    assign chirp_idx_o    = r_idx;
    assign frame_start_o  = r_fstart;
    assign frame_done_o   = r_fdone;
    assign overrun_o      = r_ovr;
    assign busy_o         = (r_state != ST_IDLE);
    assign timeout_err_o  = r_tmo;

endmodule
`default_nettype wire
